// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential shift unit: operation codes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,
        OP_ASR = 2'b01,
        OP_LSL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int STATE_W = 2;

endpackage

// File: rtl/seq_shifter_if.sv
// Control/data bundle between a requester and the sequential shift unit.
// Latency: n/a (wires only).
// Backpressure: none; requester must watch busy/done before issuing the next start.
// Ports: load_val/load_n (parallel load), start/op/amount (shift request),
//        busy/done (status), q (register contents).
interface seq_shifter_if
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic [WIDTH-1:0] load_val;
    logic             load_n;
    logic             start;
    op_e              op;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;

    modport master (
        output load_val, load_n, start, op, amount,
        input  busy, done, q
    );

    modport slave (
        input  load_val, load_n, start, op, amount,
        output busy, done, q
    );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// One-position shift/rotate of a WIDTH-bit word for the selected operation.
// Latency: purely combinational.
// Backpressure: none.
// Ports: op (operation select), q (current value), q_nxt (value after one step).
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_nxt
);

    always_comb begin
        q_nxt = q;
        case (op)
            OP_LSR:  q_nxt = {1'b0, q[WIDTH-1:1]};
            OP_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_LSL:  q_nxt = {q[WIDTH-2:0], 1'b0};
            OP_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            default: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shift register: parallel load, then LSR/ASR/LSL/ROR one position per clock.
// Latency: amount+1 cycles from start edge to done pulse; amount+2 cycles per operation.
// Backpressure: start/load ignored while busy or done; requester waits for IDLE.
// Ports: clk, reset_n (async active-low), bus (seq_shifter_if.slave).
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_shifter_if.slave  bus
);

    localparam logic [STATE_W-1:0] S_IDLE  = ST_IDLE;
    localparam logic [STATE_W-1:0] S_SHIFT = ST_SHIFT;
    localparam logic [STATE_W-1:0] S_DONE  = ST_DONE;

    logic [STATE_W-1:0] state;
    logic [AMT_W-1:0]   cnt;
    op_e                op_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   q_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op    (op_r),
        .q     (q_r),
        .q_nxt (q_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_r  <= OP_LSR;
            q_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Load has priority over start in the same cycle.
                    if (!bus.load_n) begin
                        q_r <= bus.load_val;
                    end else if (bus.start) begin
                        op_r  <= bus.op;
                        cnt   <= bus.amount;
                        state <= (bus.amount == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    q_r <= q_step;
                    cnt <= cnt - AMT_W'(1);
                    // The step that drains the counter is the last one.
                    if (cnt == AMT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status is a pure decode of registered state.
    assign bus.busy = (state == S_SHIFT);
    assign bus.done = (state == S_DONE);
    assign bus.q    = q_r;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;
    import seq_shifter_pkg::*;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seq_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] q;
        int         steps;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] step_q[$];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int done_seen = 0;
    int ops_issued = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares against the scoreboard whenever the DUT signals completion
    // or performs a shift step with a queued per-step expectation.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] s;
        if (!reset_n) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_busy && step_q.size() > 0) begin
                s = step_q.pop_front();
                check("step_q", {24'd0, bus.q}, {24'd0, s});
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_seen++;
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                check("busy_low_in_done", {31'd0, bus.busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    check("final_q", {24'd0, bus.q}, {24'd0, e.q});
                    check("busy_cycles", busy_cnt, e.steps);
                end
                busy_cnt = 0;
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
        end
    end

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        bus.load_val = v;
        bus.load_n   = 1'b0;
        @(posedge clk);
        #1;
        bus.load_n = 1'b1;
        check("load_q", {24'd0, bus.q}, {24'd0, v});
    endtask

    // Issue one shift and measure start-edge-to-done latency.
    // With junk set, start/load_n/op/amount are held at disruptive values
    // through SHIFT and DONE to show they are ignored.
    task automatic run_op(input op_e o, input logic [3:0] amt, input logic [7:0] fin, input bit junk);
        exp_t e;
        int n;
        e.q = fin;
        e.steps = int'(amt);
        exp_q.push_back(e);
        ops_issued++;
        @(negedge clk);
        bus.op     = o;
        bus.amount = amt;
        bus.load_n = 1'b1;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (junk) begin
            bus.start    = 1'b1;
            bus.load_n   = 1'b0;
            bus.load_val = 8'hFF;
            bus.op       = OP_ROR;
            bus.amount   = 4'd1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.done) break;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL done_timeout actual=none expected=done_after_%0d", int'(amt) + 1);
                break;
            end
        end
        check("done_latency", n, int'(amt) + 1);
        if (junk) begin
            @(posedge clk);
            #1;
            bus.start  = 1'b0;
            bus.load_n = 1'b1;
            check("junk_q_after_done", {24'd0, bus.q}, {24'd0, fin});
            check("junk_no_restart", {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        bus.load_val = 8'h00;
        bus.load_n   = 1'b1;
        bus.start    = 1'b0;
        bus.op       = OP_LSR;
        bus.amount   = 4'd0;

        // Reset state
        #2;
        check("rst_q", {24'd0, bus.q}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Reset mid-SHIFT: ASR by 5 aborted after 2 steps
        do_load(8'hA5);
        @(negedge clk);
        bus.op = OP_ASR;
        bus.amount = 4'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_q", {24'd0, bus.q}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        do_load(8'h0F);
        run_op(OP_ROR, 4'd4, 8'hF0, 1'b0);

        // ASR by 3 with per-step expectations
        do_load(8'hA5);
        step_q.push_back(8'hD2);
        step_q.push_back(8'hE9);
        step_q.push_back(8'hF4);
        run_op(OP_ASR, 4'd3, 8'hF4, 1'b0);
        @(negedge clk);
        check("done_cleared", {31'd0, bus.done}, 32'd0);

        do_load(8'hA5);
        run_op(OP_LSR, 4'd3, 8'h14, 1'b0);
        do_load(8'hA5);
        run_op(OP_LSL, 4'd2, 8'h94, 1'b0);
        do_load(8'h81);
        run_op(OP_ROR, 4'd9, 8'hC0, 1'b0);
        do_load(8'h81);
        run_op(OP_LSR, 4'd15, 8'h00, 1'b0);

        // amount == 0
        do_load(8'h3C);
        run_op(OP_LSL, 4'd0, 8'h3C, 1'b0);

        // Inputs held during SHIFT/DONE are ignored
        do_load(8'hA5);
        run_op(OP_LSL, 4'd4, 8'h50, 1'b1);

        // Load and start together in IDLE: load only
        @(negedge clk);
        bus.load_val = 8'h66;
        bus.load_n   = 1'b0;
        bus.start    = 1'b1;
        bus.op       = OP_LSR;
        bus.amount   = 4'd3;
        @(posedge clk);
        #1;
        bus.load_n = 1'b1;
        bus.start  = 1'b0;
        check("loadstart_q", {24'd0, bus.q}, 32'h66);
        check("loadstart_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("loadstart_busy2", {31'd0, bus.busy}, 32'd0);
        check("loadstart_done", {31'd0, bus.done}, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("step_queue_empty", step_q.size(), 32'd0);
        check("done_count", done_seen, ops_issued);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
